conv_pe_sequencer: RTL and testbench
====================================

# conv_pe_sequencer

Sequencer for the 256-lane broadcast-weight PE convolution array. Latches a job descriptor, walks IFM and weight buffer addresses for every MAC of every output tile, and drives the per-PE restart/finish strobes aligned to one-cycle buffer read latency. Collects the array's valid vector, then hands the 256-lane OFM word to the output buffer under a ready/valid handshake. Sits between the layer-control register block and the PE array with its IFM, weight and OFM buffers.

## Interface
- NUM_PE, 256: PE lanes; width of strobe and valid vectors.
- ADDR_W, 16: buffer address width.
- CNT_W, 12: width of MAC-count and tile-count fields.
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  job start pulse; sampled only in IDLE.
- cfg_num_mac  in  CNT_W  MACs per output (kernel taps x channels).
- cfg_num_tiles  in  CNT_W  output tiles in the job.
- cfg_ifm_base, cfg_w_base, cfg_ofm_base  in  ADDR_W each  buffer start addresses.
- cfg_ifm_stride  in  ADDR_W  IFM address increment between tiles.
- ifm_rd_en, w_rd_en  out  1 each  buffer read strobes; data returns next cycle.
- ifm_rd_addr, w_rd_addr  out  ADDR_W each  read addresses.
- pe_restart, pe_finish  out  NUM_PE each  per-PE strobes; all bits driven identically.
- pe_valid  in  NUM_PE  valid vector from the array.
- ofm_wr_en  out  1  OFM word valid.
- ofm_wr_addr  out  ADDR_W  OFM write address.
- ofm_ready  in  1  OFM buffer accepts word.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, ISSUE, ALIGN, DRAIN, WRITE, FIN.
- IDLE: start=1 latches all cfg_* fields, clears mac_idx/tile_idx and goes to ISSUE. If cfg_num_mac==0 or cfg_num_tiles==0, go to FIN instead; no reads or strobes are issued.
- ISSUE: ifm_rd_en=w_rd_en=1 each cycle. ifm_rd_addr=ifm_tile_base+mac_idx; w_rd_addr=w_base+mac_idx. Weights restart at w_base for every tile. mac_idx increments; after index num_mac-1 go to ALIGN.
- Strobes follow the read with one-cycle delay. pe_restart is high the cycle after the idx-0 read. pe_finish is high the cycle after the idx-(num_mac-1) read. When num_mac==1, both are high in the same cycle.
- ALIGN: a single cycle that emits the delayed last-read strobe, then goes to DRAIN.
- DRAIN: wait until &pe_valid==1, then go to WRITE. Partial valid vectors are ignored.
- WRITE: hold ofm_wr_en=1 and a stable ofm_wr_addr=ofm_base+tile_idx until ofm_ready=1. On acceptance, increment tile_idx and advance ifm_tile_base by ifm_stride, both mod 2^ADDR_W.
  - If more tiles remain, go to ISSUE with mac_idx=0.
  - Otherwise go to FIN.
- FIN: done=1 for one cycle, busy=0, return to IDLE.
- start outside IDLE is ignored. cfg_* changes after latch have no effect.
- All address arithmetic wraps modulo 2^ADDR_W with no error flag.

## Timing
- Reset values: all outputs are 0 and state is IDLE. An asynchronous assert mid-job aborts immediately; no done pulse is produced and no strobes are emitted afterwards.
- Start in cycle T: first reads at T+1, pe_restart at T+2, pe_finish at T+1+num_mac.
- Earliest ofm_wr_en is the cycle after &pe_valid is first sampled high in DRAIN.
- Back-to-back tiles: the next tile's first read is the cycle after the ofm_ready handshake.
- Job of N tiles, M MACs, zero-latency valid, ready always high: done at T+N*(M+3)+1.
- Empty job: done at T+1, busy never asserted.

## Configuration
- CONV_SEQ_PERF_CNT_EN defined: adds two 32-bit outputs.
  - perf_cycles counts every cycle with busy=1.
  - perf_stalls counts WRITE cycles with ofm_ready=0.
  - Both clear on an accepted start, saturate at 2^32-1, and reset to 0.
- Not defined: neither port nor its counters exist; all other behaviour is identical.

## Test plan
- num_mac=4, num_tiles=1, bases 0x10/0x20/0x30, valid returned 1 cycle after finish, ready=1 -> IFM addresses 0x10..0x13, pe_restart at T+2, pe_finish at T+5, one write to 0x30, done at T+8.
- num_mac=1, num_tiles=3, ifm_stride=8 -> restart and finish coincide each tile; IFM reads at base, base+8, base+16; OFM writes at ofm_base+0..2.
- ofm_ready held low 5 cycles -> ofm_wr_en and address stable for 6 cycles, no new reads issued, perf_stalls=5 with the macro defined.
- pe_valid with a single lane low for 10 cycles -> stays in DRAIN with no write; the write occurs the cycle after the lane rises.
- cfg_num_tiles=0 -> done at T+1, no rd_en, no strobes; start pulsed mid-job -> ignored, counts unchanged.
- reset_n dropped during ISSUE -> all outputs 0 asynchronously; after release, a fresh job runs correctly from IDLE.

Source files
------------

// File: rtl/conv_pe_sequencer.sv
// Job sequencer for the broadcast-weight PE array: walks IFM/weight reads per MAC, strobes the PEs, writes one OFM word per tile.
// Latency: first reads 1 cycle after start, PE strobes 1 cycle behind their reads, one tile takes num_mac+3 cycles with prompt valid/ready.
// Backpressure: stalls in DRAIN until every lane of pe_valid is high, and holds the OFM word until ofm_ready; optional perf counters under CONV_SEQ_PERF_CNT_EN.
module conv_pe_sequencer #(
    parameter int NUM_PE = 256,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_num_mac,
    input  logic [CNT_W-1:0]  cfg_num_tiles,
    input  logic [ADDR_W-1:0] cfg_ifm_base,
    input  logic [ADDR_W-1:0] cfg_w_base,
    input  logic [ADDR_W-1:0] cfg_ofm_base,
    input  logic [ADDR_W-1:0] cfg_ifm_stride,
    output logic              ifm_rd_en,
    output logic              w_rd_en,
    output logic [ADDR_W-1:0] ifm_rd_addr,
    output logic [ADDR_W-1:0] w_rd_addr,
    output logic [NUM_PE-1:0] pe_restart,
    output logic [NUM_PE-1:0] pe_finish,
    input  logic [NUM_PE-1:0] pe_valid,
    output logic              ofm_wr_en,
    output logic [ADDR_W-1:0] ofm_wr_addr,
    input  logic              ofm_ready,
    output logic              busy,
`ifdef CONV_SEQ_PERF_CNT_EN
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_stalls,
`endif
    output logic              done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_ALIGN = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;

    logic [2:0]        state;
    logic [CNT_W-1:0]  mac_idx;
    logic [CNT_W-1:0]  tile_idx;
    logic [CNT_W-1:0]  num_mac;
    logic [CNT_W-1:0]  num_tiles;
    logic [ADDR_W-1:0] ifm_tile_base;
    logic [ADDR_W-1:0] ifm_stride;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] ofm_base;
    logic              restart_q;
    logic              finish_q;

    logic issue;
    logic writing;
    logic mac_last;
    logic tile_last;
    logic accept;

    assign issue     = (state == S_ISSUE);
    assign writing   = (state == S_WRITE);
    assign mac_last  = (mac_idx == num_mac - CNT_W'(1));
    assign tile_last = (tile_idx == num_tiles - CNT_W'(1));
    assign accept    = writing && ofm_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            mac_idx       <= '0;
            tile_idx      <= '0;
            num_mac       <= '0;
            num_tiles     <= '0;
            ifm_tile_base <= '0;
            ifm_stride    <= '0;
            w_base        <= '0;
            ofm_base      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        num_mac       <= cfg_num_mac;
                        num_tiles     <= cfg_num_tiles;
                        ifm_tile_base <= cfg_ifm_base;
                        ifm_stride    <= cfg_ifm_stride;
                        w_base        <= cfg_w_base;
                        ofm_base      <= cfg_ofm_base;
                        mac_idx       <= '0;
                        tile_idx      <= '0;
                        // Degenerate jobs complete without touching the buffers or PEs.
                        if (cfg_num_mac == '0 || cfg_num_tiles == '0) begin
                            state <= S_FIN;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    mac_idx <= mac_idx + CNT_W'(1);
                    if (mac_last) begin
                        state <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (&pe_valid) begin
                        state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (ofm_ready) begin
                        tile_idx      <= tile_idx + CNT_W'(1);
                        ifm_tile_base <= ifm_tile_base + ifm_stride;
                        mac_idx       <= '0;
                        state         <= tile_last ? S_FIN : S_ISSUE;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes lag the matching read by one cycle so they line up with returning buffer data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            restart_q <= 1'b0;
            finish_q  <= 1'b0;
        end else begin
            restart_q <= issue && (mac_idx == '0);
            finish_q  <= issue && mac_last;
        end
    end

    assign ifm_rd_en   = issue;
    assign w_rd_en     = issue;
    assign ifm_rd_addr = issue ? (ifm_tile_base + ADDR_W'(mac_idx)) : '0;
    assign w_rd_addr   = issue ? (w_base + ADDR_W'(mac_idx)) : '0;
    assign pe_restart  = {NUM_PE{restart_q}};
    assign pe_finish   = {NUM_PE{finish_q}};
    assign ofm_wr_en   = writing;
    assign ofm_wr_addr = writing ? (ofm_base + ADDR_W'(tile_idx)) : '0;
    assign busy        = issue || (state == S_ALIGN) || (state == S_DRAIN) || writing;
    assign done        = (state == S_FIN);

`ifdef CONV_SEQ_PERF_CNT_EN
    logic start_acc;
    assign start_acc = (state == S_IDLE) && start;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else if (start_acc) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else begin
            if (busy && (perf_cycles != '1)) begin
                perf_cycles <= perf_cycles + 32'd1;
            end
            if (writing && !ofm_ready && (perf_stalls != '1)) begin
                perf_stalls <= perf_stalls + 32'd1;
            end
        end
    end
`endif

    logic unused_accept;
    assign unused_accept = accept;

endmodule

// File: tb/tb_conv_pe_sequencer.sv
// Bench for conv_pe_sequencer: table jobs, randomized jobs with mid-job start/cfg noise, and an async reset abort.
module tb_conv_pe_sequencer;
    localparam int NUM_PE = 256;
    localparam int ADDR_W = 16;
    localparam int CNT_W  = 12;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  cfg_num_mac = '0;
    logic [CNT_W-1:0]  cfg_num_tiles = '0;
    logic [ADDR_W-1:0] cfg_ifm_base = '0;
    logic [ADDR_W-1:0] cfg_w_base = '0;
    logic [ADDR_W-1:0] cfg_ofm_base = '0;
    logic [ADDR_W-1:0] cfg_ifm_stride = '0;
    logic              ifm_rd_en, w_rd_en;
    logic [ADDR_W-1:0] ifm_rd_addr, w_rd_addr;
    logic [NUM_PE-1:0] pe_restart, pe_finish;
    logic [NUM_PE-1:0] pe_valid = '0;
    logic              ofm_wr_en;
    logic [ADDR_W-1:0] ofm_wr_addr;
    logic              ofm_ready = 1'b0;
    logic              busy, done;
`ifdef CONV_SEQ_PERF_CNT_EN
    logic [31:0]       perf_cycles, perf_stalls;
`endif

    conv_pe_sequencer #(.NUM_PE(NUM_PE), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .cfg_num_mac(cfg_num_mac), .cfg_num_tiles(cfg_num_tiles),
        .cfg_ifm_base(cfg_ifm_base), .cfg_w_base(cfg_w_base),
        .cfg_ofm_base(cfg_ofm_base), .cfg_ifm_stride(cfg_ifm_stride),
        .ifm_rd_en(ifm_rd_en), .w_rd_en(w_rd_en),
        .ifm_rd_addr(ifm_rd_addr), .w_rd_addr(w_rd_addr),
        .pe_restart(pe_restart), .pe_finish(pe_finish), .pe_valid(pe_valid),
        .ofm_wr_en(ofm_wr_en), .ofm_wr_addr(ofm_wr_addr), .ofm_ready(ofm_ready),
        .busy(busy),
`ifdef CONV_SEQ_PERF_CNT_EN
        .perf_cycles(perf_cycles), .perf_stalls(perf_stalls),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int m;  int n;  int ib; int wb; int ob; int st;
        int d;         // cycles after pe_finish until all lanes report valid
        int s;         // WRITE cycles with ofm_ready low per tile
        int exp_done;  // cycle of done relative to the start cycle
    } vec_t;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [NUM_PE-1:0] partial_valid();
        logic [NUM_PE-1:0] v;
        v = '1;
        v[$urandom_range(0, NUM_PE-1)] = 1'b0;
        return v;
    endfunction

    task automatic chk_quiet(input string nm);
        chk({nm, "_rd_en"}, {ifm_rd_en, w_rd_en}, 0);
        chk({nm, "_rd_addr"}, ifm_rd_addr | w_rd_addr, 0);
        chk({nm, "_strobes"}, {|pe_restart, |pe_finish}, 0);
        chk({nm, "_wr"}, {ofm_wr_en, ofm_wr_addr}, 0);
        chk({nm, "_busy_done"}, {busy, done}, 0);
    endtask

    task automatic scramble_cfg();
        cfg_num_mac    = CNT_W'($urandom);
        cfg_num_tiles  = CNT_W'($urandom);
        cfg_ifm_base   = ADDR_W'($urandom);
        cfg_w_base     = ADDR_W'($urandom);
        cfg_ofm_base   = ADDR_W'($urandom);
        cfg_ifm_stride = ADDR_W'($urandom);
    endtask

    task automatic run_job(input vec_t v, input bit noise, input string tag);
        int rd_ifm[$], rd_w[$], rd_cyc[$], rs_cyc[$], fn_cyc[$], wr_addr[$];
        int cyc, done_cyc, busy_cnt, wr_cyc_cnt, wr_this, tile, fin_cyc, noise_cyc;
        int overlap, split, en_mismatch, hold_bad, exp_busy, real_job;
        bit fin_pend;
        cyc = 0; done_cyc = -1; busy_cnt = 0; wr_cyc_cnt = 0; wr_this = 0; tile = 0;
        fin_cyc = 0; overlap = 0; split = 0; en_mismatch = 0; hold_bad = 0; fin_pend = 0;
        real_job = (v.m > 0 && v.n > 0) ? 1 : 0;
        noise_cyc = (noise && real_job != 0) ? $urandom_range(2, v.exp_done - 1) : -1;
        @(negedge clk);
        cfg_num_mac    = CNT_W'(v.m);
        cfg_num_tiles  = CNT_W'(v.n);
        cfg_ifm_base   = ADDR_W'(v.ib);
        cfg_w_base     = ADDR_W'(v.wb);
        cfg_ofm_base   = ADDR_W'(v.ob);
        cfg_ifm_stride = ADDR_W'(v.st);
        start = 1'b1;
        ofm_ready = 1'b0;
        pe_valid = partial_valid();
        while (cyc < 3000 && done_cyc < 0) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            scramble_cfg();
            if (cyc == noise_cyc) start = 1'b1;
            if (ifm_rd_en) begin
                rd_ifm.push_back(int'(ifm_rd_addr));
                rd_w.push_back(int'(w_rd_addr));
                rd_cyc.push_back(cyc);
            end
            if (ifm_rd_en != w_rd_en) en_mismatch++;
            if (pe_restart != {NUM_PE{pe_restart[0]}} || pe_finish != {NUM_PE{pe_finish[0]}}) split++;
            if (pe_restart[0]) rs_cyc.push_back(cyc);
            if (pe_finish[0]) begin
                fn_cyc.push_back(cyc);
                fin_pend = 1'b1;
                fin_cyc = cyc;
            end
            if (busy) busy_cnt++;
            if (done) done_cyc = cyc;
            if (ofm_wr_en) begin
                wr_cyc_cnt++;
                wr_this++;
                if (int'(ofm_wr_addr) != ((v.ob + tile) & 16'hFFFF)) hold_bad++;
                if (ifm_rd_en) overlap++;
            end
            ofm_ready = ofm_wr_en && (wr_this > v.s);
            if (ofm_wr_en && ofm_ready) begin
                wr_addr.push_back(int'(ofm_wr_addr));
                tile++;
                wr_this = 0;
                fin_pend = 1'b0;
            end
            pe_valid = (fin_pend && cyc >= fin_cyc + v.d) ? '1 : partial_valid();
        end
        if (done_cyc < 0) begin
            chk({tag, "_timeout"}, cyc, -1);
        end
        chk({tag, "_done_cyc"}, done_cyc, v.exp_done);
        chk({tag, "_nreads"}, rd_cyc.size(), v.n * v.m * real_job);
        chk({tag, "_nrestart"}, rs_cyc.size(), v.n * real_job);
        chk({tag, "_nfinish"}, fn_cyc.size(), v.n * real_job);
        chk({tag, "_nwrites"}, wr_addr.size(), v.n * real_job);
        chk({tag, "_busy_cycles"}, busy_cnt, real_job * v.n * (v.m + 2 + v.d + v.s));
        chk({tag, "_wr_en_cycles"}, wr_cyc_cnt, real_job * v.n * (v.s + 1));
        chk({tag, "_rd_en_pair"}, en_mismatch, 0);
        chk({tag, "_lanes_uniform"}, split, 0);
        chk({tag, "_rd_during_wr"}, overlap, 0);
        chk({tag, "_wr_addr_hold"}, hold_bad, 0);
        if (real_job != 0 && rd_cyc.size() == v.n * v.m) begin
            for (int t = 0; t < v.n; t++) begin
                for (int k = 0; k < v.m; k++) begin
                    chk({tag, "_ifm_addr"}, rd_ifm[t*v.m + k], (v.ib + t*v.st + k) & 16'hFFFF);
                    chk({tag, "_w_addr"}, rd_w[t*v.m + k], (v.wb + k) & 16'hFFFF);
                end
                if (rs_cyc.size() == v.n)
                    chk({tag, "_restart_cyc"}, rs_cyc[t], rd_cyc[t*v.m] + 1);
                if (fn_cyc.size() == v.n)
                    chk({tag, "_finish_cyc"}, fn_cyc[t], rd_cyc[t*v.m + v.m - 1] + 1);
            end
        end
        if (wr_addr.size() == v.n * real_job) begin
            for (int t = 0; t < wr_addr.size(); t++)
                chk({tag, "_ofm_addr"}, wr_addr[t], (v.ob + t) & 16'hFFFF);
        end
`ifdef CONV_SEQ_PERF_CNT_EN
        chk({tag, "_perf_cycles"}, perf_cycles, real_job * v.n * (v.m + 2 + v.d + v.s));
        chk({tag, "_perf_stalls"}, perf_stalls, real_job * v.n * v.s);
`endif
        ofm_ready = 1'b0;
    endtask

    vec_t tbl[7];

    initial begin
        vec_t rv;
        tbl[0] = '{m:4, n:1, ib:'h10,   wb:'h20,   ob:'h30,   st:0,      d:1,  s:0, exp_done:8};
        tbl[1] = '{m:1, n:3, ib:'h100,  wb:'h40,   ob:'h200,  st:8,      d:1,  s:0, exp_done:13};
        tbl[2] = '{m:3, n:2, ib:'h500,  wb:'h600,  ob:'h700,  st:'h20,   d:1,  s:5, exp_done:23};
        tbl[3] = '{m:2, n:1, ib:'h80,   wb:'h90,   ob:'ha0,   st:4,      d:11, s:0, exp_done:16};
        tbl[4] = '{m:5, n:0, ib:'h1,    wb:'h2,    ob:'h3,    st:1,      d:1,  s:0, exp_done:1};
        tbl[5] = '{m:0, n:2, ib:'h1,    wb:'h2,    ob:'h3,    st:1,      d:1,  s:0, exp_done:1};
        tbl[6] = '{m:3, n:3, ib:'hfffe, wb:'hffff, ob:'hffff, st:'hfff0, d:2,  s:1, exp_done:25};

        pe_valid = partial_valid();
        #1;
        chk_quiet("reset");
`ifdef CONV_SEQ_PERF_CNT_EN
        chk("reset_perf", {perf_cycles, perf_stalls}, 0);
`endif
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++) run_job(tbl[i], 1'b0, $sformatf("tbl%0d", i));

        // Async abort while issuing reads, then a clean job afterwards.
        @(negedge clk);
        cfg_num_mac = 12'd8; cfg_num_tiles = 12'd2;
        cfg_ifm_base = 16'h40; cfg_w_base = 16'h50; cfg_ofm_base = 16'h60; cfg_ifm_stride = 16'h8;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("abort_pre_busy", {busy, ifm_rd_en}, 3);
        @(negedge clk);
        chk("abort_pre_restart", pe_restart[0], 1);
        #2 reset_n = 1'b0;
        #1 chk_quiet("abort_async");
        repeat (3) begin
            @(negedge clk);
            chk_quiet("abort_held");
        end
        reset_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk_quiet("abort_released");
        end
        run_job(tbl[0], 1'b0, "post_abort");

        for (int j = 0; j < 20; j++) begin
            rv.m = $urandom_range(1, 6);
            rv.n = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4);
            rv.ib = $urandom_range(0, 'hffff);
            rv.wb = $urandom_range(0, 'hffff);
            rv.ob = $urandom_range(0, 'hffff);
            rv.st = $urandom_range(0, 'hffff);
            rv.d = $urandom_range(1, 4);
            rv.s = $urandom_range(0, 3);
            rv.exp_done = (rv.n == 0) ? 1 : rv.n * (rv.m + 2 + rv.d + rv.s) + 1;
            run_job(rv, 1'b1, $sformatf("rnd%0d", j));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
